systolic_row_skew: RTL and testbench
====================================

Name: systolic_row_skew

Overview:
- Sits directly downstream of the row-feeder that presents one 8-element matrix-A row per cycle.
- Converts each parallel row into the diagonal wavefront the 8x8 systolic PE array needs: lane i is delayed i cycles relative to lane 0.
- Tracks stream end, drains the skew pipeline, and pulses done when the last element has left the final lane.

Parameters:
LANES, 8, number of lanes / array rows (>=1)
DW, 16, data width per lane

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  row on in_data valid this cycle
in_last  input  1  qualifies in_valid: this row is the last of the stream
in_data  input  LANES*DW  row; lane i at bits [i*DW +: DW]
in_ready  output  1  block accepts a row this cycle
out_data  output  LANES*DW  skewed lanes, lane i at [i*DW +: DW], to PE array row inputs
out_valid  output  LANES  per-lane valid
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at end of drain

Behaviour:
- Reset (async assert, sync release): out_data=0, out_valid=0, all delay stages zero/invalid, state=IDLE, drain counter=0, done=0, busy=0. in_ready is high out of reset.
- Accept: a row is accepted on a rising edge when in_valid && in_ready. When in_ready=0, in_valid, in_data and in_last are ignored.
- Skew:
  - Lane i is a shift chain of i+1 registers, each carrying {valid, data}.
  - A row accepted at edge k appears on lane i at edge k+i: lane 0 has 1-cycle register latency, lane LANES-1 appears at edge k+LANES-1.
- Bubbles: any edge without an accepted row shifts {0, 0} into stage 0 of every lane. Data in an invalid slot is forced to 0, never stale. Gaps in the input stream are therefore preserved per lane as skewed bubbles.
- in_ready is combinational: 1 in IDLE and STREAM, 0 in DRAIN.
- FSM transitions, evaluated on each accepted row unless noted:
  - IDLE -> STREAM: accepted row with in_last=0.
  - IDLE -> DRAIN: accepted row with in_last=1 (single-row stream).
  - STREAM -> STREAM: in_valid=0, or accepted row with in_last=0.
  - STREAM -> DRAIN: accepted row with in_last=1; drain counter loaded with 0.
  - DRAIN: counter increments every edge. On the edge where counter==LANES-2: state->IDLE, done<=1 for exactly one cycle, counter->0.
- Drain timing:
  - DRAIN lasts exactly LANES-1 cycles.
  - If last is accepted at edge k, done is high in the cycle after edge k+LANES-1, the same cycle the last element is visible on lane LANES-1 with out_valid[LANES-1]=1.
  - LANES=1: the last accept goes straight to IDLE with done<=1 at edge k.
- New stream after done: in the done cycle the state is IDLE and in_ready=1. A row accepted then is delayed normally; back-to-back streams have no dead cycle.
- Pipeline during DRAIN: still shifts, injecting bubbles.
- Reset mid-operation: all in-flight data is discarded, done is not pulsed, and the block returns to IDLE.
- Widths: no arithmetic on data; drain counter width is $clog2(LANES) with a minimum of 1.

Test Plan:
1. Reset then a single row: in_data lanes = 0x0010..0x0017 with in_last=1 at edge 0 -> lane i shows 0x0010+i with out_valid[i]=1 only after edge i; in_ready=0 for edges 1..7; done=1 for one cycle after edge 7; busy falls at the same edge.
2. 8-row stream, rows r=0..7, lane i data = r*16+i, last on r=7 -> lane 3 carries 0x03,0x13,...,0x73 on edges 3..10; done after edge 14; out_valid all zero afterwards.
3. Bubble: rows at edges 0, 2, 3 (in_valid=0 at edge 1) -> lane 5 valid after edges 5, 7, 8 and invalid after edge 6 with data 0x0000.
4. in_valid=1 with in_data=0xFFFF on all lanes during DRAIN -> ignored: no valid on any lane from those cycles and drain length unchanged.
5. Back-to-back streams: a second stream's first row is presented in the done cycle -> accepted; its lane 0 is valid next edge; the first stream's lane-7 output is intact.
6. reset_n pulsed low at edge 4 of scenario 2 -> outputs zero immediately (asynchronous); no done pulse; in_ready=1; a subsequent single-row stream behaves exactly as scenario 1.

Source files
------------

// File: rtl/systolic_row_skew_if.sv
// -----------------------------------------------------------------------------
// systolic_row_skew_if
// Bundle between the row feeder / PE array and the skew block.
//   in_valid  : row on in_data valid this cycle (feeder -> skew)
//   in_last   : qualifies in_valid, last row of the stream
//   in_data   : LANES*DW row, lane i at [i*DW +: DW]
//   in_ready  : skew block accepts a row this cycle
//   out_data  : skewed lanes towards the PE array rows
//   out_valid : per-lane valid
//   busy      : block is streaming or draining
//   done      : one-cycle pulse when the last element left the final lane
// Modports: master = row feeder side (drives in_*), slave = skew block.
// -----------------------------------------------------------------------------
interface systolic_row_skew_if #(
    parameter int LANES = 8,
    parameter int DW    = 16
);
    logic                  in_valid;
    logic                  in_last;
    logic [LANES*DW-1:0]   in_data;
    logic                  in_ready;
    logic [LANES*DW-1:0]   out_data;
    logic [LANES-1:0]      out_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output in_valid, in_last, in_data,
        input  in_ready, out_data, out_valid, busy, done
    );

    modport slave (
        input  in_valid, in_last, in_data,
        output in_ready, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/systolic_row_skew.sv
// -----------------------------------------------------------------------------
// systolic_row_skew
// Turns one parallel LANES-wide matrix row per cycle into the diagonal
// wavefront a systolic PE array needs: lane i is delayed i cycles relative to
// lane 0 (lane 0 itself has one register of latency). After the last row of a
// stream is accepted the block refuses input for LANES-1 cycles while the skew
// chains drain, then pulses done in the cycle the last element is visible on
// the final lane.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : systolic_row_skew_if.slave (row in, skewed lanes out, status)
// -----------------------------------------------------------------------------
module systolic_row_skew #(
    parameter int LANES = 8,
    parameter int DW    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    systolic_row_skew_if.slave   bus
);
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    // Counter value on which the drain finishes (unused when LANES == 1).
    localparam logic [CW-1:0] CNT_END = (LANES > 1) ? CW'(LANES - 2) : {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_ready;
    logic               w_accept;
    logic               w_busy;

    wire [LANES*DW-1:0] w_out_data;
    wire [LANES-1:0]    w_out_valid;

    // FSM state, drain counter and done pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_STREAM: begin
                if (w_accept && bus.in_last) begin
                    // A one-lane array has nothing to drain.
                    w_state_nxt = (LANES == 1) ? ST_IDLE : ST_DRAIN;
                end else if (w_accept) begin
                    w_state_nxt = ST_STREAM;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == CNT_END) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake, status, drain counter and done decode.
    always_comb begin
        w_ready    = (r_state != ST_DRAIN);
        w_accept   = bus.in_valid && w_ready;
        w_busy     = (r_state != ST_IDLE);
        w_cnt_nxt  = {CW{1'b0}};
        w_done_nxt = 1'b0;
        if (r_state == ST_DRAIN) begin
            if (r_cnt == CNT_END) begin
                w_cnt_nxt  = {CW{1'b0}};
                w_done_nxt = 1'b1;
            end else begin
                w_cnt_nxt  = r_cnt + CW'(1);
                w_done_nxt = 1'b0;
            end
        end else begin
            w_cnt_nxt  = {CW{1'b0}};
            w_done_nxt = (LANES == 1) && w_accept && bus.in_last;
        end
    end

    // Lane i is a chain of i+1 {valid, data} stages; the last stage drives the
    // lane output. Every edge shifts, so input gaps travel down as bubbles.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [gi:0]   r_vld;
        logic [DW-1:0] r_dat [0:gi];

        // Shift chain for this lane; invalid slots always carry zero data.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int s = 0; s <= gi; s++) begin
                    r_vld[s] <= 1'b0;
                    r_dat[s] <= {DW{1'b0}};
                end
            end else begin
                r_vld[0] <= w_accept;
                r_dat[0] <= w_accept ? bus.in_data[gi*DW +: DW] : {DW{1'b0}};
                for (int s = 1; s <= gi; s++) begin
                    r_vld[s] <= r_vld[s-1];
                    r_dat[s] <= r_dat[s-1];
                end
            end
        end

        assign w_out_valid[gi]          = r_vld[gi];
        assign w_out_data[gi*DW +: DW]  = r_dat[gi];
    end

    assign bus.in_ready  = w_ready;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.out_data  = w_out_data;
    assign bus.out_valid = w_out_valid;

endmodule

// File: tb/tb_systolic_row_skew.sv
// -----------------------------------------------------------------------------
// tb_systolic_row_skew
// Self-checking bench: a history of accepted rows indexed by clock edge is the
// reference. Lane i after edge n must show the row accepted at edge n-i (or a
// zero bubble); readiness, busy and done follow from the edge of the last
// accepted last-row. Directed scenarios pin the reference with literal values,
// then a randomized stream (with occasional resets) is checked every cycle.
// -----------------------------------------------------------------------------
module tb_systolic_row_skew;
    localparam int LANES = 8;
    localparam int DW    = 16;
    localparam int HN    = 4096;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    systolic_row_skew_if #(.LANES(LANES), .DW(DW)) bus ();

    systolic_row_skew #(.LANES(LANES), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int  checks    = 0;
    int  errors    = 0;
    int  cyc       = 0;      // rising edges seen so far
    int  last_edge = -100;   // edge at which the last row was accepted
    int  drain_end = -100;   // edge after which done must be high
    bit  in_stream = 1'b0;
    bit  cmp_en    = 1'b0;
    bit                  hv [HN];
    logic [LANES*DW-1:0] hd [HN];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_ready(input int n);
        return !(n >= last_edge && n < drain_end);
    endfunction

    function automatic logic [LANES*DW-1:0] mk_row(input int base, input int step);
        logic [LANES*DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(base + i * step);
        return r;
    endfunction

    function automatic logic [DW-1:0] lane(input int i);
        return bus.out_data[i*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HN; i++) begin
            hv[i] = 1'b0;
            hd[i] = '0;
        end
        last_edge = -100;
        drain_end = -100;
        in_stream = 1'b0;
    endtask

    // Drive one cycle of input, update the reference at the edge, return #1 later.
    task automatic cycle(input logic v, input logic l, input logic [LANES*DW-1:0] d);
        bit acc;
        bus.in_valid = v;
        bus.in_last  = l;
        bus.in_data  = d;
        acc = v && m_ready(cyc) && reset_n;
        @(posedge clk);
        cyc++;
        hv[cyc] = acc;
        hd[cyc] = acc ? d : '0;
        if (acc && l) begin
            last_edge = cyc;
            drain_end = cyc + LANES - 1;
            in_stream = 1'b0;
        end else if (acc) begin
            in_stream = 1'b1;
        end
        #1;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, '0);
    endtask

    // Every-cycle comparison of all outputs against the reference.
    always @(negedge clk) begin : cmp
        int n;
        bit ev;
        logic [DW-1:0] ed;
        if (cmp_en) begin
            for (int i = 0; i < LANES; i++) begin
                n  = cyc - i;
                ev = (n >= 0 && n < HN) ? hv[n] : 1'b0;
                ed = (n >= 0 && n < HN) ? hd[n][i*DW +: DW] : '0;
                chk($sformatf("lane%0d_valid", i), 32'(bus.out_valid[i]), 32'(ev));
                chk($sformatf("lane%0d_data", i), 32'(lane(i)), 32'(ed));
            end
            chk("in_ready", 32'(bus.in_ready), 32'(m_ready(cyc)));
            chk("busy", 32'(bus.busy), 32'(in_stream || !m_ready(cyc)));
            chk("done", 32'(bus.done), 32'(cyc == drain_end));
        end
    end

    // Single row 0x0010..0x0017 with last: literal wavefront and drain timing.
    task automatic single_row();
        cycle(1'b1, 1'b1, mk_row(16'h0010, 1));
        chk("s1_lane0", 32'(lane(0)), 32'h0010);
        chk("s1_busy", 32'(bus.busy), 32'd1);
        for (int i = 1; i < LANES; i++) begin
            idle_cycle();
            chk($sformatf("s1_lane%0d", i), 32'(lane(i)), 32'h0010 + 32'(i));
            chk($sformatf("s1_v%0d", i), 32'(bus.out_valid), 32'(1) << i);
            if (i < LANES - 1) chk("s1_ready_low", 32'(bus.in_ready), 32'd0);
        end
        chk("s1_done", 32'(bus.done), 32'd1);
        chk("s1_busy_fall", 32'(bus.busy), 32'd0);
        chk("s1_ready_back", 32'(bus.in_ready), 32'd1);
        idle_cycle();
        chk("s1_done_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        model_reset();
        repeat (3) idle_cycle();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(|bus.out_data), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        idle_cycle();

        // Scenario 1
        single_row();

        // Scenario 2: 8-row stream, lane i of row r = r*16+i
        for (int e = 0; e < 16; e++) begin
            cycle(e < 8, e == 7, (e < 8) ? mk_row(e * 16, 1) : '0);
            if (e >= 3 && e <= 10) chk("s2_lane3", 32'(lane(3)), 32'((e - 3) * 16 + 3));
            if (e == 13) chk("s2_no_early_done", 32'(bus.done), 32'd0);
            if (e == 14) chk("s2_done", 32'(bus.done), 32'd1);
            if (e == 15) chk("s2_all_idle", 32'(bus.out_valid), 32'd0);
        end

        // Scenario 3: rows at edges 0,2,3 with a gap at edge 1
        for (int e = 0; e < 12; e++) begin
            cycle(e == 0 || e == 2 || e == 3, e == 3, mk_row(16'h0100 * (e + 1), 1));
            if (e == 5 || e == 7 || e == 8) chk("s3_lane5_valid", 32'(bus.out_valid[5]), 32'd1);
            if (e == 6) begin
                chk("s3_lane5_bubble", 32'(bus.out_valid[5]), 32'd0);
                chk("s3_lane5_zero", 32'(lane(5)), 32'd0);
            end
        end

        // Scenario 4: input offered during drain must be ignored
        cycle(1'b1, 1'b1, mk_row(16'h0200, 1));
        for (int e = 1; e < LANES; e++) cycle(1'b1, 1'b0, {LANES{16'hFFFF}});
        chk("s4_done", 32'(bus.done), 32'd1);
        chk("s4_only_lane7", 32'(bus.out_valid), 32'h80);
        chk("s4_lane7", 32'(lane(7)), 32'h0207);
        idle_cycle();

        // Scenario 5: next stream's first row offered in the done cycle
        cycle(1'b1, 1'b1, mk_row(16'h0A00, 1));
        for (int e = 1; e < LANES; e++) idle_cycle();
        chk("s5_done", 32'(bus.done), 32'd1);
        chk("s5_ready", 32'(bus.in_ready), 32'd1);
        chk("s5_lane7_intact", 32'(lane(7)), 32'h0A07);
        cycle(1'b1, 1'b1, mk_row(16'h0B00, 1));
        chk("s5_lane0_valid", 32'(bus.out_valid[0]), 32'd1);
        chk("s5_lane0", 32'(lane(0)), 32'h0B00);
        chk("s5_done_gone", 32'(bus.done), 32'd0);
        for (int e = 0; e < LANES; e++) idle_cycle();

        // Scenario 6: reset in the middle of a stream
        for (int e = 0; e < 5; e++) cycle(1'b1, 1'b0, mk_row(e * 16, 1));
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("s6_valid_zero", 32'(bus.out_valid), 32'd0);
        chk("s6_data_zero", 32'(|bus.out_data), 32'd0);
        chk("s6_ready", 32'(bus.in_ready), 32'd1);
        chk("s6_busy", 32'(bus.busy), 32'd0);
        chk("s6_done", 32'(bus.done), 32'd0);
        repeat (2) idle_cycle();
        reset_n = 1'b1;
        idle_cycle();
        single_row();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            logic v;
            logic l;
            logic [LANES*DW-1:0] d;
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                model_reset();
                repeat (2) idle_cycle();
                reset_n = 1'b1;
            end
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 7) == 0);
            for (int w = 0; w < LANES; w++) d[w*DW +: DW] = DW'($urandom);
            cycle(v, l, d);
        end
        repeat (LANES + 2) idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
